// File: rtl/sata_link_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sata_link_tx_ctrl
// Purpose  : Link-layer TX sequencer: FIFO frame accounting, slot request,
//            word streaming / local frame drop and end-of-frame status report.
// Revision : 1.0
// ============================================================================
module sata_link_tx_ctrl #(
    parameter int FRAME_CNT_W   = 4,
    parameter int GRANT_TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_frame_done,
    input  logic [31:0]            fifo_data,
    input  logic                   fifo_eop,
    input  logic                   fifo_err,
    input  logic                   fifo_empty,
    output logic                   fifo_rdreq,
    output logic                   tx_req,
    input  logic                   tx_grant,
    output logic [31:0]            tx_data,
    output logic                   tx_valid,
    output logic                   tx_eop,
    input  logic                   tx_ready,
    input  logic                   tx_done,
    input  logic                   tx_good,
    output logic                   stat_ok,
    output logic                   stat_fail,
    output logic [FRAME_CNT_W-1:0] frames_pending,
    output logic                   busy
);

    localparam int                     TO_W      = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [TO_W-1:0]        c_TO_LAST = TO_W'(GRANT_TIMEOUT - 1);
    localparam logic [FRAME_CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_DATA = 3'd2,
        S_WAIT = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [FRAME_CNT_W-1:0]   r_frames;
    logic [FRAME_CNT_W-1:0]   w_frames_next;
    logic [TO_W-1:0]          r_to_cnt;
    logic                     r_stat_ok;
    logic                     r_stat_fail;
    logic                     w_stat_ok;
    logic                     w_stat_fail;
    logic                     w_inc;
    logic                     w_dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        tx_req      = 1'b0;
        tx_valid    = 1'b0;
        tx_eop      = 1'b0;
        tx_data     = '0;
        fifo_rdreq  = 1'b0;
        w_stat_ok   = 1'b0;
        w_stat_fail = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Error flag is only meaningful on the first word of a frame
                if (r_frames != '0) begin
                    w_next = fifo_err ? S_DROP : S_REQ;
                end
            end
            S_REQ: begin
                tx_req = 1'b1;
                if (tx_grant) begin
                    w_next = S_DATA;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_DATA: begin
                tx_valid   = !fifo_empty;
                tx_data    = fifo_data;
                tx_eop     = fifo_eop & !fifo_empty;
                fifo_rdreq = tx_valid & tx_ready;
                if (fifo_rdreq && fifo_eop) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    w_stat_ok   = tx_good;
                    w_stat_fail = !tx_good;
                    w_next      = S_IDLE;
                end
            end
            S_DROP: begin
                fifo_rdreq = !fifo_empty;
                if (fifo_rdreq && fifo_eop) begin
                    w_stat_fail = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_inc = wr_frame_done;
    assign w_dec = fifo_rdreq & fifo_eop;

    // Simultaneous push and pop of an EOP leaves the count unchanged
    always_comb begin
        w_frames_next = r_frames;
        if (w_inc && !w_dec && (r_frames != c_CNT_MAX)) begin
            w_frames_next = r_frames + FRAME_CNT_W'(1);
        end else if (w_dec && !w_inc && (r_frames != '0)) begin
            w_frames_next = r_frames - FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frames    <= '0;
            r_to_cnt    <= '0;
            r_stat_ok   <= 1'b0;
            r_stat_fail <= 1'b0;
        end else begin
            r_frames    <= w_frames_next;
            r_to_cnt    <= (r_state == S_REQ) ? r_to_cnt + TO_W'(1) : '0;
            r_stat_ok   <= w_stat_ok;
            r_stat_fail <= w_stat_fail;
        end
    end

    assign stat_ok        = r_stat_ok;
    assign stat_fail      = r_stat_fail;
    assign frames_pending = r_frames;
    assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire
